serial_load_feeder: RTL
=======================

Name: serial_load_feeder

Overview:
- Sending end of the `permit`/`values[1:16]` load interface. Feeds the array loader, which expands each value into a pair of output cells.
- Accepts a serial bitstream through a valid/ready handshake and assembles N_VALUES bits into one frame.
- Presents the frame on `values` and pulses `permit` for a programmable number of cycles.
- Decouples a slow serial source (UART/SPI front end, test bench) from the parallel loader.

Parameters:
- N_VALUES, 16, frame width in bits; must match the loader's `values` width.
- HOLD_CYCLES, 1, number of cycles `permit` stays high per frame (1..15).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- bit_in  input  1  serial data bit
- bit_valid  input  1  `bit_in` is valid this cycle
- bit_ready  output  1  feeder can accept a bit this cycle
- abort  input  1  discard the partial frame
- values  output  [1:N_VALUES]  assembled frame, to the loader
- permit  output  1  load strobe, to the loader
- busy  output  1  frame in progress (SHIFT/PARITY/LOAD)
- frame_done  output  1  one-cycle pulse, frame delivered
- err  output  1  one-cycle pulse, frame rejected

Behaviour:
- All outputs registered except `bit_ready`, which is decoded from state and forced 0 while `rst`=1.
- Reset values: state IDLE, cnt=0, values=0, permit=0, busy=0, frame_done=0, err=0.
- A bit is accepted on a rising edge where `bit_valid`&&`bit_ready`.
- Bit order: the first accepted bit lands in `values[1]`, the Nth in `values[N_VALUES]`.
- Bits assemble in an internal shift register; `values` does not change during assembly.
- States:
  - IDLE: `bit_ready`=1, busy=0. An accepted bit → SHIFT, cnt=1.
  - SHIFT: `bit_ready`=1, busy=1. Each accepted bit increments cnt. When the accepted bit makes cnt=N_VALUES → LOAD, or → PARITY if the feature is enabled.
  - LOAD: `bit_ready`=0. On entry `values` <= shift register and `permit`=1, held for HOLD_CYCLES cycles. `frame_done`=1 on the last permit cycle. Then → IDLE, permit=0.
- Latency: Nth bit accepted at edge k → `values`/`permit` valid in cycle k+1 → ready for the next frame's first bit at cycle k+1+HOLD_CYCLES.
- `values` holds the last delivered frame until the next LOAD; it is stable whenever `permit`=0.
- `bit_valid` low mid-frame: wait indefinitely; no timeout.
- `abort`=1 in SHIFT/PARITY: → IDLE next edge, cnt=0, partial bits dropped, `values` unchanged, no `err`.
- `abort` in LOAD: ignored; the frame completes.
- `abort` and an accepted bit in the same cycle: abort wins; the bit is dropped.
- `rst` mid-frame or mid-LOAD: next edge gives reset values (`permit` drops, `values`=0).

Optional Feature:
- Macro: PARITY_CHECK_EN.
- Defined:
  - Each frame carries one extra trailing bit, giving even parity over N_VALUES+1 bits.
  - State PARITY (`bit_ready`=1) accepts that bit.
  - Match → LOAD.
  - Mismatch → IDLE, `err`=1 for one cycle, no `permit`, `values` unchanged.
- Not defined: no PARITY state, frames are exactly N_VALUES bits, `err` tied 0.

Test Plan:
- Reset, then 16 bits 1010_0101_1100_0011 with `bit_valid` held high → `values`=16'hA5C3 and `permit`=1 one cycle after the 16th accepted bit, for 1 cycle; `frame_done` coincident; `bit_ready`=0 that cycle.
- HOLD_CYCLES=3, frame 16'hFFFF → `permit` high exactly 3 cycles, `frame_done` on the 3rd; the next frame's first bit is not accepted until `bit_ready` returns.
- Send 7 bits, pulse `abort`, then full frame 16'h0001 → only 16'h0001 is delivered, one `permit` pulse, `values` stays 0 until then.
- `bit_valid` toggled 1/0 every cycle for frame 16'h8001 → same result as back-to-back; `busy`=1 throughout assembly.
- Assert `rst` during LOAD with HOLD_CYCLES=4 → next edge `permit`=0, `values`=0, state IDLE, `bit_ready` low while `rst` high.
- PARITY_CHECK_EN: frame 16'h0003 with parity bit 0 → delivered; same frame with parity bit 1 → `err` pulse, no `permit`, `values` retains the previous frame.

Source files
------------

// File: rtl/serial_load_feeder.sv
// Serial-to-parallel frame feeder for the permit/values loader interface.
// Optional trailing even-parity bit per frame: define PARITY_CHECK_EN.
module serial_load_feeder #(
  parameter int N_VALUES    = 16,
  parameter int HOLD_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  input  logic              abort,
  output logic [1:N_VALUES] values,
  output logic              permit,
  output logic              busy,
  output logic              frame_done,
  output logic              err
);

  localparam int CW = $clog2(N_VALUES + 1);
  localparam int HW = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    LOAD   = 2'd2
`ifdef PARITY_CHECK_EN
    ,
    PARITY = 2'd3
`endif
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [1:N_VALUES] sh_q;
  logic [1:N_VALUES] sh_d;
  logic [1:N_VALUES] values_q;
  logic [HW-1:0]     hold_q;
  logic              permit_q;
  logic              busy_q;
  logic              done_q;
  logic              accept;
  logic              last_bit;
`ifdef PARITY_CHECK_EN
  logic              par_q;
  logic              err_q;
`endif

  // Ready is decoded from state; LOAD blocks new bits, reset blocks all.
  assign bit_ready = !rst && (state_q != LOAD);
  assign accept    = bit_valid && bit_ready;

  // First bit shifts in at the tail and ends up in position 1.
  assign sh_d      = {sh_q[2:N_VALUES], bit_in};
  assign last_bit  = (cnt_q == CW'(N_VALUES - 1));

  assign values     = values_q;
  assign permit     = permit_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
`ifdef PARITY_CHECK_EN
  assign err        = err_q;
`else
  assign err        = 1'b0;
`endif

  // Frame FSM: assemble bits, then hold permit for HOLD_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      values_q <= '0;
      hold_q   <= '0;
      permit_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_q    <= 1'b0;
      err_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef PARITY_CHECK_EN
      err_q  <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (accept && !abort) begin
            sh_q    <= sh_d;
            cnt_q   <= CW'(1);
            busy_q  <= 1'b1;
            state_q <= SHIFT;
`ifdef PARITY_CHECK_EN
            par_q   <= bit_in;
`endif
          end
        end
        SHIFT: begin
          if (abort) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (accept) begin
            sh_q  <= sh_d;
            cnt_q <= cnt_q + CW'(1);
`ifdef PARITY_CHECK_EN
            par_q <= par_q ^ bit_in;
            if (last_bit) begin
              state_q <= PARITY;
            end
`else
            if (last_bit) begin
              state_q  <= LOAD;
              values_q <= sh_d;
              permit_q <= 1'b1;
              hold_q   <= HW'(HOLD_CYCLES - 1);
              done_q   <= (HOLD_CYCLES == 1);
            end
`endif
          end
        end
`ifdef PARITY_CHECK_EN
        PARITY: begin
          if (abort) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (accept) begin
            cnt_q <= '0;
            // Even parity over data plus trailing bit.
            if (par_q == bit_in) begin
              state_q  <= LOAD;
              values_q <= sh_q;
              permit_q <= 1'b1;
              hold_q   <= HW'(HOLD_CYCLES - 1);
              done_q   <= (HOLD_CYCLES == 1);
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
            end
          end
        end
`endif
        LOAD: begin
          if (hold_q == '0) begin
            state_q  <= IDLE;
            permit_q <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
          end else begin
            hold_q <= hold_q - HW'(1);
            done_q <= (hold_q == HW'(1));
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
